adc_scan_control: RTL and testbench
===================================

ADC_SCAN_CONTROL -- requirements
Module: adc_scan_control

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of scanned channels (1..8).
REQ-002 Parameter DATA_W, default 12, SHALL set the sample width in bits.
REQ-003 Parameter PERIOD, default 650_000, SHALL set the idle cycles between scans (minimum 2).
REQ-004 Parameter TIMEOUT, default 1024, SHALL set the maximum cycles spent waiting for one conversion (minimum 1).
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 en_mask  in  N_CH  SHALL carry the per-channel scan enables (1 = scan).
REQ-008 adc_data  in  DATA_W  SHALL carry the converter result.
REQ-009 adc_valid  in  1  SHALL qualify adc_data for one cycle.
REQ-010 adc_req  out  1  SHALL be a one-cycle conversion request pulse.
REQ-011 ch_sel  out  N_CH  SHALL give the one-hot select of the channel being converted.
REQ-012 ch_data  out  N_CH*DATA_W  SHALL hold the packed per-channel results, channel k at bits [k*DATA_W +: DATA_W].
REQ-013 frame_tick  out  1  SHALL pulse for one cycle at the end of each scan.
REQ-014 timeout_err  out  1  SHALL pulse for one cycle when a conversion times out.

Function
REQ-015 The FSM SHALL use states IDLE, SELECT, REQ, WAIT, NEXT and TICK.
REQ-016 In IDLE the period counter SHALL increment each cycle; at count PERIOD-1 it SHALL clear and the FSM SHALL go to SELECT if the latched mask is nonzero, else stay in IDLE with no tick.
REQ-017 On leaving IDLE, en_mask SHALL be latched; later mask changes SHALL affect only the next scan.
REQ-018 SELECT SHALL load ch_sel with the lowest enabled channel and hold one settle cycle, then go to REQ.
REQ-019 REQ SHALL assert adc_req for exactly one cycle, then go to WAIT.
REQ-020 In WAIT, adc_valid SHALL write adc_data into the current channel slot in the next cycle, then go to NEXT.
REQ-021 If TIMEOUT WAIT cycles pass without adc_valid, timeout_err SHALL pulse, the slot SHALL keep its old value, and the FSM SHALL go to NEXT.
REQ-022 adc_valid in the same cycle as timeout expiry SHALL be accepted as data, with no timeout_err.
REQ-023 adc_valid outside WAIT SHALL be ignored.
REQ-024 NEXT SHALL move to the next higher enabled channel (update ch_sel, then REQ); if none remains, it SHALL go to TICK.
REQ-025 TICK SHALL assert frame_tick for one cycle, then return to IDLE with the counter at 0.
REQ-026 Between scans, ch_sel SHALL hold the last converted channel.
REQ-027 ch_data slots of disabled channels SHALL be left unchanged.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: IDLE, counter 0, ch_data 0, ch_sel = channel 0 one-hot, adc_req/frame_tick/timeout_err 0, latched mask 0, and any in-flight conversion SHALL be discarded.
REQ-029 The first scan SHALL start PERIOD cycles after rst_n deasserts.

Configuration
REQ-030 With ADC_SCAN_AVG_EN defined, each enabled channel SHALL be converted 4 times back to back (REQ/WAIT repeated).
REQ-031 With ADC_SCAN_AVG_EN defined, results SHALL be summed in a DATA_W+2-bit accumulator, and the slot SHALL get the sum right-shifted by 2 (truncated).
REQ-032 With ADC_SCAN_AVG_EN defined, a timeout on any of the 4 conversions SHALL abort that channel, leave its slot unchanged, and pulse timeout_err once.
REQ-033 Without ADC_SCAN_AVG_EN, the block SHALL do one conversion per channel and SHALL contain no accumulator logic.

Structure
REQ-034 Package adc_scan_pkg SHALL hold the FSM state encoding and the averaging constants (AVG_CNT=4, AVG_SHIFT=2).
REQ-035 Sub-module adc_scan_next_ch SHALL be purely combinational: from the latched mask and current index, it SHALL return the next higher enabled index plus a none-left flag.

Verification (N_CH=4, DATA_W=12, PERIOD=10, TIMEOUT=8)
REQ-036 Mask 4'b1111 with adc_valid 3 cycles after each adc_req and data 0x111/0x222/0x333/0x444: ch_sel SHALL walk 0001..1000, ch_data SHALL equal 0x444_333_222_111, and there SHALL be one frame_tick.
REQ-037 Mask 4'b1010: only ch_sel 0010 and 1000 SHALL be issued, and slots 0 and 2 SHALL stay 0.
REQ-038 No adc_valid on channel 2: timeout_err SHALL pulse 8 WAIT cycles after adc_req, slot 2 SHALL be unchanged, and the scan SHALL finish with frame_tick.
REQ-039 Mask 4'b0000: over 50 cycles there SHALL be no adc_req and no frame_tick; then mask 4'b0001 SHALL start a scan at the next period boundary.
REQ-040 rst_n pulsed low during WAIT: outputs SHALL reset immediately, and the next adc_req SHALL come only after PERIOD+2 cycles.
REQ-041 With ADC_SCAN_AVG_EN and channel 0 samples 0x100, 0x101, 0x102, 0x104: slot 0 SHALL be 0x101.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC scan controller: FSM state encoding and the
// averaging constants used when ADC_SCAN_AVG_EN is defined.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StReq,
    StWait,
    StNext,
    StTick
  } scan_state_e;

  // Conversions per channel and matching divide-by shift in averaging builds.
  localparam int unsigned AVG_CNT   = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/adc_scan_next_ch.sv
// Combinational next-channel finder: returns the lowest enabled index strictly
// above cur_idx, or raises none_left when no such channel exists.
module adc_scan_next_ch #(
  parameter int unsigned N_CH = 4,
  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] mask,
  input  logic [IdxW-1:0] cur_idx,
  output logic [IdxW-1:0] next_idx,
  output logic            none_left
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_idx))) begin
        next_idx  = IdxW'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_control.sv
// Periodic multi-channel ADC scan controller. Every PERIOD idle cycles it walks
// the enabled channels in ascending order, requests one conversion per channel
// and stores the results in packed per-channel slots.
// Optional feature macro: ADC_SCAN_AVG_EN -- four back-to-back conversions per
// channel, slot receives their truncated average.
module adc_scan_control
  import adc_scan_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned PERIOD  = 650_000,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          en_mask,
  input  logic [DATA_W-1:0]        adc_data,
  input  logic                     adc_valid,
  output logic                     adc_req,
  output logic [N_CH-1:0]          ch_sel,
  output logic [N_CH*DATA_W-1:0]   ch_data,
  output logic                     frame_tick,
  output logic                     timeout_err
);

  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CntW = $clog2(PERIOD);
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  scan_state_e             state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ToW-1:0]          wcnt_q, wcnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [N_CH-1:0]         ch_sel_q, ch_sel_d;
  logic [N_CH-1:0]         mask_q, mask_d;
  logic [N_CH*DATA_W-1:0]  ch_data_q, ch_data_d;
  logic                    tmo_q, tmo_d;
  logic [IdxW-1:0]         low_idx;
  logic [IdxW-1:0]         next_idx;
  logic                    none_left;
`ifdef ADC_SCAN_AVG_EN
  logic [DATA_W+1:0]       acc_q, acc_d;
  logic [1:0]              avg_q, avg_d;
  logic [DATA_W+1:0]       sum;
`endif

  adc_scan_next_ch #(
    .N_CH (N_CH)
  ) u_next_ch (
    .mask      (mask_q),
    .cur_idx   (idx_q),
    .next_idx  (next_idx),
    .none_left (none_left)
  );

  // Lowest enabled channel of the live mask, used when a scan starts.
  always_comb begin
    low_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en_mask[i]) low_idx = IdxW'(i);
    end
  end

  // Next-state logic for the scan sequencer and result slots.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    ch_sel_d  = ch_sel_q;
    mask_d    = mask_q;
    ch_data_d = ch_data_q;
    tmo_d     = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    acc_d     = acc_q;
    avg_d     = avg_q;
    sum       = acc_q + {2'b00, adc_data};
`endif
    unique case (state_q)
      StIdle: begin
        if (cnt_q == CntW'(PERIOD - 1)) begin
          cnt_d  = '0;
          // Mask is sampled once per period boundary; an all-zero mask skips the scan.
          mask_d = en_mask;
          if (|en_mask) begin
            state_d  = StSelect;
            idx_d    = low_idx;
            ch_sel_d = N_CH'(1) << low_idx;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSelect: begin
        // Settle cycle with the first channel already selected.
        state_d = StReq;
`ifdef ADC_SCAN_AVG_EN
        acc_d   = '0;
        avg_d   = '0;
`endif
      end
      StReq: begin
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // Valid wins over timeout expiry in the same cycle.
        if (adc_valid) begin
`ifdef ADC_SCAN_AVG_EN
          if (avg_q == 2'(AVG_CNT - 1)) begin
            ch_data_d[int'(idx_q)*DATA_W +: DATA_W] = sum[AVG_SHIFT +: DATA_W];
            state_d = StNext;
          end else begin
            acc_d   = sum;
            avg_d   = avg_q + 2'd1;
            state_d = StReq;
          end
`else
          ch_data_d[int'(idx_q)*DATA_W +: DATA_W] = adc_data;
          state_d = StNext;
`endif
        end else if (wcnt_q == ToW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = StNext;
        end else begin
          wcnt_d = wcnt_q + ToW'(1);
        end
      end
      StNext: begin
        if (none_left) begin
          state_d = StTick;
        end else begin
          idx_d    = next_idx;
          ch_sel_d = N_CH'(1) << next_idx;
          state_d  = StReq;
        end
`ifdef ADC_SCAN_AVG_EN
        acc_d = '0;
        avg_d = '0;
`endif
      end
      StTick: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset drops any in-flight conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      idx_q     <= '0;
      ch_sel_q  <= N_CH'(1);
      mask_q    <= '0;
      ch_data_q <= '0;
      tmo_q     <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_q     <= '0;
      avg_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      ch_sel_q  <= ch_sel_d;
      mask_q    <= mask_d;
      ch_data_q <= ch_data_d;
      tmo_q     <= tmo_d;
`ifdef ADC_SCAN_AVG_EN
      acc_q     <= acc_d;
      avg_q     <= avg_d;
`endif
    end
  end

  assign adc_req     = (state_q == StReq);
  assign frame_tick  = (state_q == StTick);
  assign timeout_err = tmo_q;
  assign ch_sel      = ch_sel_q;
  assign ch_data     = ch_data_q;

endmodule

// File: tb/tb_adc_scan_control.sv
// Self-checking bench for adc_scan_control: directed scan table, randomized
// scans against a behavioural model, mask-zero and mid-conversion reset cases.
module tb_adc_scan_control;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned PERIOD  = 10;
  localparam int unsigned TIMEOUT = 8;
  localparam int          SCAN_BUDGET = 600;
`ifdef ADC_SCAN_AVG_EN
  localparam int          AVG_N = 4;
`else
  localparam int          AVG_N = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_CH-1:0]        en_mask;
  logic [DATA_W-1:0]      adc_data;
  logic                   adc_valid;
  logic                   adc_req;
  logic [N_CH-1:0]        ch_sel;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic                   frame_tick;
  logic                   timeout_err;

  adc_scan_control #(
    .N_CH    (N_CH),
    .DATA_W  (DATA_W),
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_mask     (en_mask),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .adc_req     (adc_req),
    .ch_sel      (ch_sel),
    .ch_data     (ch_data),
    .frame_tick  (frame_tick),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder script: delay (cycles after the adc_req cycle) and data for
  // conversion k of channel ch. Delay 0 lands in the request cycle; above
  // TIMEOUT means the converter never answers.
  int                resp_d [N_CH][AVG_N];
  logic [DATA_W-1:0] resp_v [N_CH][AVG_N];

  // Observations of the last scan.
  logic [N_CH*DATA_W-1:0] obs_data;
  logic [N_CH-1:0]        obs_seen;
  int obs_err, obs_req, obs_first, obs_ticks;
  bit obs_order_ok;

  // Reference slot contents.
  logic [DATA_W-1:0] exp_slots [N_CH];

  typedef struct packed {
    logic [N_CH-1:0]        mask;
    logic [N_CH*4-1:0]      dly;
    logic [N_CH*DATA_W-1:0] data;
    logic [N_CH*DATA_W-1:0] exp_data;
    logic [3:0]             exp_err;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N_CH-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < N_CH; i++) if (v[i]) oh_idx = i;
  endfunction

  // Run one complete scan with the given mask, acting as the converter.
  task automatic run_scan(input logic [N_CH-1:0] mask, input bit scramble);
    int conv_k [N_CH];
    int pend, last_req, last_ch, d;
    logic [DATA_W-1:0] pdata;
    logic [N_CH-1:0] exp_sel;
    bit done;
    for (int i = 0; i < N_CH; i++) conv_k[i] = 0;
    pend = -1; last_req = 0; last_ch = -1; done = 1'b0; pdata = '0;
    obs_err = 0; obs_req = 0; obs_first = -1; obs_ticks = 0;
    obs_seen = '0; obs_order_ok = 1'b1; obs_data = '0;
    en_mask = mask;
    for (int cyc = 1; cyc <= SCAN_BUDGET && !done; cyc++) begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_valid = 1'b1;
          adc_data  = pdata;
          pend      = -1;
        end
      end
      if (timeout_err) begin
        obs_err++;
        chk("timeout_latency", 64'(cyc - last_req), 64'(TIMEOUT + 1));
      end
      if (adc_req) begin
        int ch;
        ch = oh_idx(ch_sel);
        chk("ch_sel_onehot", 64'($countones(ch_sel)), 64'd1);
        if (obs_first < 0) obs_first = cyc;
        obs_req++;
        if (ch < last_ch) obs_order_ok = 1'b0;
        last_ch  = ch;
        last_req = cyc;
        if (ch >= 0) begin
          obs_seen[ch] = 1'b1;
          if (conv_k[ch] < AVG_N) begin
            d     = resp_d[ch][conv_k[ch]];
            pdata = resp_v[ch][conv_k[ch]];
            conv_k[ch]++;
            if (d == 0) begin
              adc_valid = 1'b1;
              adc_data  = pdata;
            end else if (d <= int'(TIMEOUT)) begin
              pend = d;
            end
          end
        end
        if (scramble && obs_req == 1) en_mask = N_CH'($urandom);
      end
      if (frame_tick) begin
        obs_ticks++;
        obs_data = ch_data;
        done     = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL scan_budget: no frame_tick within %0d cycles", SCAN_BUDGET);
    end
    @(negedge clk);
    adc_valid = 1'b0;
    chk("frame_tick_one_cycle", 64'(frame_tick), 64'd0);
    if (last_ch >= 0) begin
      exp_sel = N_CH'(1) << last_ch;
      chk("ch_sel_hold_after_scan", 64'(ch_sel), 64'(exp_sel));
    end
  endtask

  // Behavioural reference: channels ascending, AVG_N conversions each; any
  // missed conversion aborts the channel with one error and keeps the slot.
  task automatic model_scan(input logic [N_CH-1:0] mask, output int e_err, output int e_req);
    int sum;
    bit ok;
    e_err = 0;
    e_req = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (mask[ch]) begin
        ok  = 1'b1;
        sum = 0;
        for (int k = 0; k < AVG_N && ok; k++) begin
          e_req++;
          if (resp_d[ch][k] >= 1 && resp_d[ch][k] <= int'(TIMEOUT)) begin
            sum += int'(resp_v[ch][k]);
          end else begin
            e_err++;
            ok = 1'b0;
          end
        end
        if (ok) exp_slots[ch] = DATA_W'(sum / AVG_N);
      end
    end
  endtask

  function automatic logic [N_CH*DATA_W-1:0] pack_exp();
    pack_exp = '0;
    for (int ch = 0; ch < N_CH; ch++) pack_exp[ch*DATA_W +: DATA_W] = exp_slots[ch];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_CH*DATA_W-1:0] tmp;
    logic [N_CH*4-1:0]      dl;
    logic [N_CH-1:0]        rmask;
    int e_err, e_req, lat, r, n_req, n_tick;
    bit found;

    tbl[0] = '{mask: 4'b1010, dly: 16'h3333, data: 48'hddd_ccc_bbb_aaa,
               exp_data: 48'hddd_000_bbb_000, exp_err: 4'd0};
    tbl[1] = '{mask: 4'b1111, dly: 16'h3333, data: 48'h444_333_222_111,
               exp_data: 48'h444_333_222_111, exp_err: 4'd0};
    tbl[2] = '{mask: 4'b1111, dly: 16'h8952, data: 48'h888_777_666_555,
               exp_data: 48'h888_333_666_555, exp_err: 4'd1};
    tbl[3] = '{mask: 4'b0101, dly: 16'h9190, data: 48'h000_abc_000_999,
               exp_data: 48'h888_abc_666_555, exp_err: 4'd1};
    tbl[4] = '{mask: 4'b1000, dly: 16'h9000, data: 48'h123_000_000_000,
               exp_data: 48'h888_abc_666_555, exp_err: 4'd1};

    rst_n = 1'b0; en_mask = '0; adc_valid = 1'b0; adc_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_adc_req", 64'(adc_req), 64'd0);
    chk("reset_ch_sel", 64'(ch_sel), 64'd1);
    chk("reset_ch_data", 64'(ch_data), 64'd0);
    chk("reset_frame_tick", 64'(frame_tick), 64'd0);
    chk("reset_timeout_err", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      dl   = tbl[t].dly;
      tmp  = tbl[t].data;
      for (int ch = 0; ch < N_CH; ch++) begin
        for (int k = 0; k < AVG_N; k++) begin
          resp_d[ch][k] = int'(dl[ch*4 +: 4]);
          resp_v[ch][k] = tmp[ch*DATA_W +: DATA_W];
        end
      end
      run_scan(tbl[t].mask, 1'b0);
      if (t == 0) chk("first_scan_req_latency", 64'(obs_first), 64'(PERIOD + 1));
      chk("tbl_ch_data", 64'(obs_data), 64'(tbl[t].exp_data));
      chk("tbl_timeout_count", 64'(obs_err), 64'(tbl[t].exp_err));
      chk("tbl_channels_seen", 64'(obs_seen), 64'(tbl[t].mask));
      chk("tbl_ascending_order", 64'(obs_order_ok), 64'd1);
      chk("tbl_frame_ticks", 64'(obs_ticks), 64'd1);
    end

    tmp = tbl[4].exp_data;
    for (int ch = 0; ch < N_CH; ch++) exp_slots[ch] = tmp[ch*DATA_W +: DATA_W];

    // Randomized scans against the reference model.
    for (int s = 0; s < 12; s++) begin
      rmask = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int ch = 0; ch < N_CH; ch++) begin
        for (int k = 0; k < AVG_N; k++) begin
          r = int'($urandom_range(0, 9));
          if (r < 7) resp_d[ch][k] = int'($urandom_range(1, TIMEOUT));
          else if (r == 7) resp_d[ch][k] = 0;
          else resp_d[ch][k] = int'(TIMEOUT) + 1;
          resp_v[ch][k] = DATA_W'($urandom);
        end
      end
      model_scan(rmask, e_err, e_req);
      run_scan(rmask, 1'b1);
      chk("rand_ch_data", 64'(obs_data), 64'(pack_exp()));
      chk("rand_timeout_count", 64'(obs_err), 64'(e_err));
      chk("rand_req_count", 64'(obs_req), 64'(e_req));
      chk("rand_channels_seen", 64'(obs_seen), 64'(rmask));
    end

`ifdef ADC_SCAN_AVG_EN
    // Averaging: 0x100+0x101+0x102+0x104 = 0x407, >>2 = 0x101.
    resp_d[0][0] = 2; resp_v[0][0] = 12'h100;
    resp_d[0][1] = 2; resp_v[0][1] = 12'h101;
    resp_d[0][2] = 2; resp_v[0][2] = 12'h102;
    resp_d[0][3] = 2; resp_v[0][3] = 12'h104;
    run_scan(4'b0001, 1'b0);
    chk("avg_slot0", 64'(obs_data[DATA_W-1:0]), 64'h101);
    chk("avg_req_count", 64'(obs_req), 64'd4);
`endif

    // All-zero mask: no activity, then a one-channel mask restarts scanning.
    en_mask = '0;
    n_req = 0; n_tick = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (adc_req) n_req++;
      if (frame_tick) n_tick++;
    end
    chk("mask_zero_no_req", 64'(n_req), 64'd0);
    chk("mask_zero_no_tick", 64'(n_tick), 64'd0);
    for (int k = 0; k < AVG_N; k++) begin
      resp_d[0][k] = 3;
      resp_v[0][k] = 12'h5a5;
    end
    run_scan(4'b0001, 1'b0);
    chk("mask_restart_latency_ok",
        64'(obs_first >= 2 && obs_first <= int'(PERIOD) + 1), 64'd1);
    chk("mask_restart_slot0", 64'(obs_data[DATA_W-1:0]), 64'h5a5);

    // Reset asserted while waiting on a conversion.
    en_mask = 4'b1111;
    found = 1'b0;
    for (int c = 0; c < SCAN_BUDGET && !found; c++) begin
      @(negedge clk);
      if (adc_req) found = 1'b1;
    end
    chk("rst_test_req_seen", 64'(found), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_adc_req", 64'(adc_req), 64'd0);
    chk("rst_async_ch_sel", 64'(ch_sel), 64'd1);
    chk("rst_async_ch_data", 64'(ch_data), 64'd0);
    chk("rst_async_frame_tick", 64'(frame_tick), 64'd0);
    chk("rst_async_timeout_err", 64'(timeout_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int c = 1; c <= SCAN_BUDGET && lat < 0; c++) begin
      @(negedge clk);
      adc_valid = (c == 2);
      adc_data  = 12'hfff;
      if (adc_req) lat = c;
    end
    adc_valid = 1'b0;
    chk("post_reset_req_latency", 64'(lat), 64'(PERIOD + 1));
    chk("idle_valid_ignored", 64'(ch_data), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
